// File: rtl/strobed_wait_memory.sv
// Strobed wait-state memory: independent read/write channels, self-clearing init after reset.
// Optional write-first forwarding on same-address collisions: STROBED_WAIT_MEMORY_BYPASS_EN.
module strobed_wait_memory #(
  parameter int WORD_SIZE = 16,
  parameter int LANE_SIZE = 8,
  parameter logic [WORD_SIZE-1:0] WORD_INIT = {WORD_SIZE{1'b0}},
  parameter int ADDRESS_SIZE = 4,
  parameter int MEMORY_QTY = 16,
  parameter int WAIT_SIZE = 4,
  parameter int READ_WAIT = 0,
  parameter int WRITE_WAIT = 0,
  localparam int LANES = WORD_SIZE / LANE_SIZE
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    r_req_valid,
  output logic                    r_req_ready,
  input  logic [ADDRESS_SIZE-1:0] r_addr,
  output logic [WORD_SIZE-1:0]    r_data,
  output logic                    r_resp_valid,
  output logic                    r_resp_err,
  input  logic                    w_req_valid,
  output logic                    w_req_ready,
  input  logic [ADDRESS_SIZE-1:0] w_addr,
  input  logic [WORD_SIZE-1:0]    w_data,
  input  logic [LANES-1:0]        w_strb,
  output logic                    w_resp_valid,
  output logic                    w_resp_err,
  output logic                    init_done
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  localparam int LAST_I = MEMORY_QTY - 1;
  localparam logic [ADDRESS_SIZE:0]   QTY_L     = MEMORY_QTY[ADDRESS_SIZE:0];
  localparam logic [ADDRESS_SIZE-1:0] LAST_L    = LAST_I[ADDRESS_SIZE-1:0];
  localparam logic [ADDRESS_SIZE-1:0] ADDR_ZERO = {ADDRESS_SIZE{1'b0}};
  localparam logic [ADDRESS_SIZE-1:0] ADDR_ONE  = {{(ADDRESS_SIZE-1){1'b0}}, 1'b1};
  localparam logic [WAIT_SIZE-1:0]    R_WAIT_L  = READ_WAIT[WAIT_SIZE-1:0];
  localparam logic [WAIT_SIZE-1:0]    W_WAIT_L  = WRITE_WAIT[WAIT_SIZE-1:0];
  localparam logic [WAIT_SIZE-1:0]    WAIT_ZERO = {WAIT_SIZE{1'b0}};
  localparam logic [WAIT_SIZE-1:0]    WAIT_ONE  = {{(WAIT_SIZE-1){1'b0}}, 1'b1};

  logic [WORD_SIZE-1:0]    mem [MEMORY_QTY];
  logic [ADDRESS_SIZE-1:0] init_cnt_r;
  state_t                  r_state_r, w_state_r;
  logic [WAIT_SIZE-1:0]    r_cnt_r, w_cnt_r;
  logic [WORD_SIZE-1:0]    r_buf_r;
  logic                    r_err_r, w_err_r;
  logic [WORD_SIZE-1:0]    rd_word_s;

  wire r_acc_s     = r_req_valid & r_req_ready;
  wire w_acc_s     = w_req_valid & w_req_ready;
  wire r_inr_s     = ({1'b0, r_addr} < QTY_L);
  wire w_inr_s     = ({1'b0, w_addr} < QTY_L);
  wire init_last_s = ~init_done & (init_cnt_r == LAST_L);

  // Word captured by a read accept; out-of-range reads return WORD_INIT.
  always_comb begin
    rd_word_s = WORD_INIT;
    if (r_inr_s) begin
      rd_word_s = mem[r_addr];
`ifdef STROBED_WAIT_MEMORY_BYPASS_EN
      if (w_acc_s && (w_addr == r_addr)) begin
        for (int i = 0; i < LANES; i++) begin
          if (w_strb[i]) begin
            rd_word_s[i*LANE_SIZE +: LANE_SIZE] = w_data[i*LANE_SIZE +: LANE_SIZE];
          end else begin
            rd_word_s[i*LANE_SIZE +: LANE_SIZE] = mem[r_addr][i*LANE_SIZE +: LANE_SIZE];
          end
        end
      end else begin
        rd_word_s = mem[r_addr];
      end
`endif
    end else begin
      rd_word_s = WORD_INIT;
    end
  end

  // Init sequencer: one word cleared per edge, init_done on the last one.
  always_ff @(posedge clock) begin
    if (reset) begin
      init_cnt_r <= ADDR_ZERO;
      init_done  <= 1'b0;
    end else if (!init_done) begin
      init_cnt_r <= init_cnt_r + ADDR_ONE;
      if (init_last_s) begin
        init_done <= 1'b1;
      end
    end
  end

  // Storage: init clearing, then strobed in-range writes on the accept edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (!init_done) begin
        mem[init_cnt_r] <= WORD_INIT;
      end else if (w_acc_s && w_inr_s) begin
        for (int i = 0; i < LANES; i++) begin
          if (w_strb[i]) begin
            mem[w_addr][i*LANE_SIZE +: LANE_SIZE] <= w_data[i*LANE_SIZE +: LANE_SIZE];
          end
        end
      end
    end
  end

  // Read channel FSM with registered handshake and response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_r    <= ST_INIT;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_data       <= {WORD_SIZE{1'b0}};
      r_buf_r      <= {WORD_SIZE{1'b0}};
      r_err_r      <= 1'b0;
      r_cnt_r      <= WAIT_ZERO;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state_r)
        ST_INIT: begin
          if (init_last_s) begin
            r_req_ready <= 1'b1;
            r_state_r   <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (r_acc_s) begin
            r_buf_r     <= rd_word_s;
            r_err_r     <= ~r_inr_s;
            r_req_ready <= 1'b0;
            r_cnt_r     <= R_WAIT_L;
            r_state_r   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt_r != WAIT_ZERO) begin
            r_cnt_r <= r_cnt_r - WAIT_ONE;
          end else begin
            r_data       <= r_buf_r;
            r_resp_valid <= 1'b1;
            r_resp_err   <= r_err_r;
            r_req_ready  <= 1'b1;
            r_state_r    <= ST_IDLE;
          end
        end
        default: begin
          r_req_ready <= 1'b0;
          r_state_r   <= ST_INIT;
        end
      endcase
    end
  end

  // Write channel FSM; the memory itself is updated by the storage block.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_r    <= ST_INIT;
      w_req_ready  <= 1'b0;
      w_resp_valid <= 1'b0;
      w_resp_err   <= 1'b0;
      w_err_r      <= 1'b0;
      w_cnt_r      <= WAIT_ZERO;
    end else begin
      w_resp_valid <= 1'b0;
      w_resp_err   <= 1'b0;
      case (w_state_r)
        ST_INIT: begin
          if (init_last_s) begin
            w_req_ready <= 1'b1;
            w_state_r   <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_acc_s) begin
            w_err_r     <= ~w_inr_s;
            w_req_ready <= 1'b0;
            w_cnt_r     <= W_WAIT_L;
            w_state_r   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_cnt_r != WAIT_ZERO) begin
            w_cnt_r <= w_cnt_r - WAIT_ONE;
          end else begin
            w_resp_valid <= 1'b1;
            w_resp_err   <= w_err_r;
            w_req_ready  <= 1'b1;
            w_state_r    <= ST_IDLE;
          end
        end
        default: begin
          w_req_ready <= 1'b0;
          w_state_r   <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strobed_wait_memory.sv
// Scoreboard bench for strobed_wait_memory: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_strobed_wait_memory;

  localparam int QTY = 12;
  localparam int READ_WAIT = 2;
  localparam int WRITE_WAIT = 3;
  localparam logic [15:0] WINIT = 16'hA5A5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        r_req_valid = 1'b0, w_req_valid = 1'b0;
  logic [3:0]  r_addr = 4'd0, w_addr = 4'd0;
  logic [15:0] w_data = 16'h0000;
  logic [1:0]  w_strb = 2'b00;
  logic        r_req_ready, w_req_ready, r_resp_valid, r_resp_err;
  logic        w_resp_valid, w_resp_err, init_done;
  logic [15:0] r_data;

  strobed_wait_memory #(
    .WORD_SIZE(16), .LANE_SIZE(8), .WORD_INIT(WINIT), .ADDRESS_SIZE(4),
    .MEMORY_QTY(QTY), .WAIT_SIZE(4), .READ_WAIT(READ_WAIT), .WRITE_WAIT(WRITE_WAIT)
  ) dut (
    .clock(clock), .reset(reset),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_addr(r_addr),
    .r_data(r_data), .r_resp_valid(r_resp_valid), .r_resp_err(r_resp_err),
    .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_addr(w_addr),
    .w_data(w_data), .w_strb(w_strb), .w_resp_valid(w_resp_valid),
    .w_resp_err(w_resp_err), .init_done(init_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] data;
    bit          err;
    int          due;
  } exp_t;

  exp_t        rq[$];
  exp_t        wq[$];
  exp_t        re, we;
  logic [15:0] model_mem [16];
  int          tests = 0, fails = 0, cyc = 0, w_pulses = 0, drv_edge = 0;
  bit          last_r_err = 1'b0, last_w_err = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard on every response pulse.
  always @(negedge clock) begin
    if (r_resp_valid === 1'b1) begin
      tests++;
      last_r_err = r_resp_err;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL read_unexpected: got data %h err %0b, no response required", r_data, r_resp_err);
      end else begin
        re = rq.pop_front();
        if (r_data !== re.data || r_resp_err !== re.err || cyc != re.due) begin
          fails++;
          $display("FAIL read_resp: got data %h err %0b edge %0d, required data %h err %0b edge %0d",
                   r_data, r_resp_err, cyc, re.data, re.err, re.due);
        end
      end
    end
    if (w_resp_valid === 1'b1) begin
      tests++;
      w_pulses++;
      last_w_err = w_resp_err;
      if (wq.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected: got err %0b, no response required", w_resp_err);
      end else begin
        we = wq.pop_front();
        if (w_resp_err !== we.err || cyc != we.due) begin
          fails++;
          $display("FAIL write_resp: got err %0b edge %0d, required err %0b edge %0d",
                   w_resp_err, cyc, we.err, we.due);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] lane_mask(input logic [1:0] s);
    logic [15:0] m;
    m = 16'h0000;
    for (int i = 0; i < 2; i++) if (s[i]) m = m | (16'h00FF << (8 * i));
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = WINIT;
  endtask

  // One cycle of stimulus; the model is updated for whatever the DUT will accept.
  task automatic drive(input bit rv, input logic [3:0] ra, input bit wv, input logic [3:0] wa,
                       input logic [15:0] wd, input logic [1:0] ws, output bit racc, output bit wacc);
    exp_t        e;
    logic [15:0] m;
    @(negedge clock);
    r_req_valid = rv; r_addr = ra;
    w_req_valid = wv; w_addr = wa; w_data = wd; w_strb = ws;
    racc = rv && (r_req_ready === 1'b1);
    wacc = wv && (w_req_ready === 1'b1);
    drv_edge = cyc + 1;
    if (racc) begin
      if (int'(ra) < QTY) begin
        e.data = model_mem[ra];
        e.err  = 1'b0;
`ifdef STROBED_WAIT_MEMORY_BYPASS_EN
        if (wacc && wa == ra) begin
          m = lane_mask(ws);
          e.data = (e.data & ~m) | (wd & m);
        end
`endif
      end else begin
        e.data = WINIT;
        e.err  = 1'b1;
      end
      e.due = drv_edge + READ_WAIT + 1;
      rq.push_back(e);
    end
    if (wacc) begin
      e.data = 16'h0000;
      e.err  = (int'(wa) >= QTY);
      e.due  = drv_edge + WRITE_WAIT + 1;
      wq.push_back(e);
      if (int'(wa) < QTY) begin
        m = lane_mask(ws);
        model_mem[wa] = (model_mem[wa] & ~m) | (wd & m);
      end
    end
    @(posedge clock);
  endtask

  task automatic idle();
    bit a, b;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 2'b00, a, b);
  endtask

  task automatic rd(input logic [3:0] addr);
    bit a, b;
    int n = 0;
    do begin
      drive(1'b1, addr, 1'b0, 4'd0, 16'h0000, 2'b00, a, b);
      n++;
    end while (!a && n < 50);
    if (!a) check("rd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [15:0] d, input logic [1:0] s);
    bit a, b;
    int n = 0;
    do begin
      drive(1'b0, 4'd0, 1'b1, addr, d, s, a, b);
      n++;
    end while (!b && n < 50);
    if (!b) check("wr_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin
      idle();
      n++;
    end
    idle();
    if (rq.size() != 0 || wq.size() != 0) check("response_timeout", rq.size() + wq.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; r_req_valid = 1'b0; w_req_valid = 1'b0;
    rq.delete(); wq.delete(); model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", {r_data, r_req_ready, w_req_ready, r_resp_valid, r_resp_err,
                          w_resp_valid, w_resp_err, init_done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= QTY; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("init_edge_%0d", k), {init_done, r_req_ready, w_req_ready},
            (k == QTY) ? 32'd7 : 32'd0);
    end
  endtask

  initial begin
    bit          ra, wa;
    int          last_r, last_w, p0;
    logic [15:0] coll_exp;

    do_reset();
    for (int a = 0; a < QTY; a++) rd(4'(a));
    wait_quiet();

    // Strobes
    wr(4'd3, 16'h1234, 2'b11);
    wr(4'd3, 16'hFFFF, 2'b01);
    rd(4'd3);
    wait_quiet();
    check("strobe_merge", r_data, 16'h12FF);

    // Out of range
    wr(4'd13, 16'hBEEF, 2'b11);
    wait_quiet();
    check("oor_w_err", last_w_err, 1'b1);
    rd(4'd13);
    wait_quiet();
    check("oor_r_err", last_r_err, 1'b1);
    check("oor_r_data", r_data, WINIT);
    for (int a = 0; a < QTY; a++) rd(4'(a));
    wait_quiet();

    // Collision
    wr(4'd5, 16'h0001, 2'b11);
    wait_quiet();
    drive(1'b1, 4'd5, 1'b1, 4'd5, 16'hABCD, 2'b10, ra, wa);
    check("collision_same_edge", {ra, wa}, 2'b11);
    wait_quiet();
`ifdef STROBED_WAIT_MEMORY_BYPASS_EN
    coll_exp = 16'hAB01;
`else
    coll_exp = 16'h0001;
`endif
    check("collision_read", r_data, coll_exp);
    rd(4'd5);
    wait_quiet();
    check("collision_after", r_data, 16'hAB01);

    // Random traffic on both channels
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            16'($urandom), 2'($urandom_range(0, 3)), ra, wa);
    end
    wait_quiet();

    // Back-to-back: both valids held high
    last_r = -1;
    last_w = -1;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 1'b1, 4'($urandom_range(0, 15)),
            16'($urandom), 2'($urandom_range(0, 3)), ra, wa);
      if (ra) begin
        if (last_r >= 0) check("rd_interval", drv_edge - last_r, READ_WAIT + 2);
        last_r = drv_edge;
      end
      if (wa) begin
        if (last_w >= 0) check("wr_interval", drv_edge - last_w, WRITE_WAIT + 2);
        last_w = drv_edge;
      end
    end
    wait_quiet();

    // Reset while a write is in flight
    wr(4'd2, 16'h5A5A, 2'b11);
    p0 = w_pulses;
    idle();
    do_reset();
    repeat (WRITE_WAIT + 2) idle();
    check("reset_no_w_resp", w_pulses - p0, 32'd0);
    rd(4'd2);
    wait_quiet();
    check("reset_recleared", r_data, WINIT);
    for (int a = 0; a < QTY; a++) rd(4'(a));
    wait_quiet();

    check("queues_empty", rq.size() + wq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
